// File: rtl/inta_sequencer.sv
`timescale 1ns/1ps
// Generates the two-pulse INTA handshake to an 8259-style PIC and captures the vector on the second pulse.
// Latency: INTA falls 1 cycle after intr&int_enable; vector_valid rises 2*PULSE+GAP cycles after that.
// Backpressure: vector_valid holds the vector until vector_ready; RECOVER then blocks retrigger for GAP cycles.
module inta_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intr,
  input  logic       int_enable,
  input  logic [7:0] data_in,
  input  logic       data_oe,
  input  logic       vector_ready,
  output logic       int_ack,
  output logic [7:0] vector,
  output logic       vector_valid,
  output logic       spurious,
  output logic       busy,
  output logic [7:0] spurious_count
);

  typedef enum logic [2:0] {IDLE, ACK1, GAP, ACK2, HOLD, RECOVER} state_t;

  localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       capture;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (intr && int_enable) begin
          state_nxt = ACK1;
          cnt_nxt   = PULSE_LOAD;
        end
      end
      ACK1: begin
        if (cnt == 4'd0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      GAP: begin
        if (cnt == 4'd0) begin
          state_nxt = ACK2;
          cnt_nxt   = PULSE_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACK2: begin
        // The PIC only drives the vector late in the second pulse, so sample on its final cycle.
        if (cnt == 4'd0) begin
          state_nxt = HOLD;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (vector_ready) begin
          state_nxt = RECOVER;
          cnt_nxt   = GAP_LOAD;
        end
      end
      RECOVER: begin
        if (cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      int_ack        <= 1'b1;
      vector         <= 8'h00;
      spurious       <= 1'b0;
      spurious_count <= 8'h00;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      // Registered from the next state so the strobe is a clean flop output.
      int_ack <= !((state_nxt == ACK1) || (state_nxt == ACK2));
      if (capture) begin
        if (data_oe) begin
          vector   <= data_in;
          spurious <= 1'b0;
        end else begin
          vector   <= 8'hFF;
          spurious <= 1'b1;
          if (spurious_count != 8'hFF) begin
            spurious_count <= spurious_count + 8'd1;
          end
        end
      end
    end
  end

  assign vector_valid = (state == HOLD);
  assign busy         = (state != IDLE);

endmodule

// File: doc/inta_sequencer.md
INTA_SEQUENCER -- requirements
Module: inta_sequencer

Interface
REQ-001 SHALL declare parameter PULSE_CYCLES, default 2: INTA low time in clk cycles, legal range 1..15.
REQ-002 SHALL declare parameter GAP_CYCLES, default 2: INTA high time between pulses and post-handshake recovery time in clk cycles, legal range 1..15.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 intr  input  1  INT request from the PIC.
REQ-007 int_enable  input  1  CPU interrupt-enable flag; a new sequence starts only while high.
REQ-008 data_in  input  8  PIC data bus.
REQ-009 data_oe  input  1  PIC data-bus drive indication (PIC out_control_logic_data).
REQ-010 vector_ready  input  1  consumer accepts the vector.
REQ-011 int_ack  output  1  INTA strobe to the PIC, active low, registered.
REQ-012 vector  output  8  captured interrupt vector.
REQ-013 vector_valid  output  1  vector available; held until accepted.
REQ-014 spurious  output  1  qualifies vector: no PIC drive seen during second pulse.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 spurious_count  output  8  saturating count of spurious sequences.

Function
REQ-017 SHALL implement states IDLE, ACK1, GAP, ACK2, HOLD and RECOVER, with a 4-bit down-counter timing ACK1, GAP, ACK2 and RECOVER.
REQ-018 IDLE: int_ack=1; intr=1 and int_enable=1 sampled on an edge -> ACK1, with int_ack=0 from the next cycle (1-cycle latency).
REQ-019 ACK1: int_ack=0 for exactly PULSE_CYCLES cycles -> GAP.
REQ-020 GAP: int_ack=1 for exactly GAP_CYCLES cycles -> ACK2.
REQ-021 ACK2: int_ack=0 for exactly PULSE_CYCLES cycles -> HOLD.
REQ-022 On the last ACK2 cycle: data_oe=1 -> vector<=data_in, spurious<=0; data_oe=0 -> vector<=8'hFF, spurious<=1, spurious_count+1.
REQ-023 spurious_count SHALL saturate at 8'hFF and never wrap.
REQ-024 HOLD: int_ack=1 and vector_valid=1; vector and spurious stable; the cycle with vector_valid=1 and vector_ready=1 -> RECOVER.
REQ-025 RECOVER: vector_valid=0 for GAP_CYCLES cycles -> IDLE; intr is ignored here so a lingering INT does not retrigger.
REQ-026 A vector_ready already high on HOLD entry SHALL complete the handshake in the first HOLD cycle.
REQ-027 intr or int_enable falling after IDLE SHALL NOT abort the sequence; both pulses always complete (PIC requirement).
REQ-028 int_ack SHALL be glitch-free: the low periods are exactly 2 x PULSE_CYCLES cycles per sequence, in two pulses.
REQ-029 vector_valid SHALL be high only in HOLD; busy SHALL equal (state != IDLE).

Reset
REQ-030 reset=1 SHALL force state IDLE, counter 0, int_ack=1, vector=8'h00, vector_valid=0, spurious=0, busy=0 and spurious_count=8'h00 at the next edge.
REQ-031 Reset asserted mid-sequence, including while int_ack=0, SHALL drive int_ack=1 on the following cycle; the partial vector is discarded.
REQ-032 reset SHALL take priority over every other input in the same cycle.

Verification
REQ-033 Defaults: intr=1 and int_enable=1 for one cycle, PIC drives data_in=8'h4A with data_oe=1 in ACK2 -> int_ack low 2, high 2, low 2 cycles; vector=8'h4A, spurious=0, vector_valid high until vector_ready.
REQ-034 data_oe held 0 throughout -> vector=8'hFF, spurious=1, spurious_count 0->1; with 256 such sequences the count stays at 8'hFF.
REQ-035 intr=1 with int_enable=0 for 20 cycles -> int_ack stays 1 and busy stays 0; raising int_enable starts ACK1 on the next cycle.
REQ-036 vector_ready held 0 for 10 HOLD cycles, then 1 -> vector stable for all 10 cycles; intr still high -> no new ACK1 until GAP_CYCLES recovery cycles elapse.
REQ-037 reset pulsed during the 2nd ACK2 cycle -> next cycle int_ack=1, vector_valid=0, spurious_count unchanged from 0; the sequence restarts cleanly afterwards.
REQ-038 PULSE_CYCLES=1 and GAP_CYCLES=1 -> int_ack pattern 0,1,0 over three consecutive cycles and the vector is captured on the single ACK2 cycle.
